// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction memory loader/sequencer.
// Parity storage is enabled by defining IMEM_PARITY_EN.
package imem_pkg;

   localparam int DEFAULT_DEPTH  = 64;
   localparam int DEFAULT_DATA_W = 32;
   localparam int MAX_DATA_W     = 64;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_DONE
   } state_e;

   // Even parity: the returned bit makes the total count of ones even.
   function automatic logic even_parity(input logic [MAX_DATA_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: synchronous write, asynchronous read, no reset.
// The word width includes the parity bit when IMEM_PARITY_EN is defined.
module imem_ram #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6,
   parameter int WIDTH  = 32
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WIDTH-1:0]  rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_dma_seq.sv
// Instruction memory with a host load port and a valid/ready issue stream.
// Optional IMEM_PARITY_EN adds per-word even parity, wr_par_flip and par_err.
//
// Issue handshake: a word moves when instr_valid && instr_ready at a rising
// edge; while instr_valid is high and instr_ready low, instr_data/instr_addr
// are held. Write port: a word is written when wr_valid && wr_ready.
module imem_dma_seq
   import imem_pkg::*;
#(
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_req,
   output logic              load_ack,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              start,
   input  logic [ADDR_W:0]   prog_len,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr_data,
   output logic [ADDR_W-1:0] instr_addr,
   output logic              busy,
   output logic              done,
   output logic              len_err,
`ifdef IMEM_PARITY_EN
   input  logic              wr_par_flip,
   output logic              par_err,
`endif
   output state_e            dbg_state_o
);

`ifdef IMEM_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
`else
   localparam int MEM_W = DATA_W;
`endif

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

   state_e            state_q;
   logic [ADDR_W:0]   len_q;
   logic [ADDR_W:0]   rd_ptr_q;
   logic              instr_valid_q;
   logic [DATA_W-1:0] instr_data_q;
   logic [ADDR_W-1:0] instr_addr_q;
   logic              load_ack_q;
   logic              wr_ready_q;
   logic              busy_q;
   logic              done_q;
   logic              len_err_q;

   logic              mem_we;
   logic [MEM_W-1:0]  mem_wdata;
   logic [MEM_W-1:0]  mem_rdata;
   logic              out_free;
   logic              words_left;
   logic              bad_len;
   logic              rd_par_bad;

   assign mem_we     = wr_valid && wr_ready_q;
   assign out_free   = !instr_valid_q || instr_ready;
   assign words_left = rd_ptr_q < len_q;
   assign bad_len    = (prog_len == '0) || (prog_len > DEPTH_L);

`ifdef IMEM_PARITY_EN
   logic par_err_q;
   assign mem_wdata  = {even_parity(MAX_DATA_W'(wr_data)) ^ wr_par_flip, wr_data};
   assign rd_par_bad = even_parity(MAX_DATA_W'(mem_rdata[DATA_W-1:0])) != mem_rdata[DATA_W];
   assign par_err    = par_err_q;
`else
   assign mem_wdata  = wr_data;
   assign rd_par_bad = 1'b0;
`endif

   imem_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .WIDTH  (MEM_W)
   ) u_ram (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (wr_addr),
      .wdata_i (mem_wdata),
      .raddr_i (rd_ptr_q[ADDR_W-1:0]),
      .rdata_o (mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         len_q         <= '0;
         rd_ptr_q      <= '0;
         instr_valid_q <= 1'b0;
         instr_data_q  <= '0;
         instr_addr_q  <= '0;
         load_ack_q    <= 1'b0;
         wr_ready_q    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         len_err_q     <= 1'b0;
`ifdef IMEM_PARITY_EN
         par_err_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (load_req) begin
                  state_q    <= ST_LOAD;
                  load_ack_q <= 1'b1;
                  wr_ready_q <= 1'b1;
               end else if (start) begin
                  if (bad_len) begin
                     len_err_q <= 1'b1;
                  end else begin
                     len_err_q <= 1'b0;
                     len_q     <= prog_len;
                     rd_ptr_q  <= '0;
                     busy_q    <= 1'b1;
                     state_q   <= ST_RUN;
`ifdef IMEM_PARITY_EN
                     par_err_q <= 1'b0;
`endif
                  end
               end
            end
            ST_LOAD: begin
               if (!load_req) begin
                  state_q    <= ST_IDLE;
                  load_ack_q <= 1'b0;
                  wr_ready_q <= 1'b0;
               end
            end
            ST_RUN: begin
               // Host takeover wins over issuing; no completion pulse on abort.
               if (load_req) begin
                  state_q       <= ST_LOAD;
                  instr_valid_q <= 1'b0;
                  busy_q        <= 1'b0;
                  load_ack_q    <= 1'b1;
                  wr_ready_q    <= 1'b1;
               end else if (out_free) begin
                  if (words_left) begin
                     instr_data_q  <= mem_rdata[DATA_W-1:0];
                     instr_addr_q  <= rd_ptr_q[ADDR_W-1:0];
                     instr_valid_q <= 1'b1;
                     rd_ptr_q      <= rd_ptr_q + ONE_L;
`ifdef IMEM_PARITY_EN
                     if (rd_par_bad) begin
                        par_err_q <= 1'b1;
                     end
`endif
                  end else begin
                     instr_valid_q <= 1'b0;
                     busy_q        <= 1'b0;
                     done_q        <= 1'b1;
                     state_q       <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign load_ack    = load_ack_q;
   assign wr_ready    = wr_ready_q;
   assign instr_valid = instr_valid_q;
   assign instr_data  = instr_data_q;
   assign instr_addr  = instr_addr_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign len_err     = len_err_q;
   assign dbg_state_o = state_q;

`ifndef IMEM_PARITY_EN
   logic unused_par;
   assign unused_par = rd_par_bad;
`endif

endmodule

// File: tb/tb_imem_dma_seq.sv
// Scoreboard bench for imem_dma_seq: a memory model predicts every issued word,
// a negedge monitor pops and compares. Covers IMEM_PARITY_EN when defined.
module tb_imem_dma_seq;
   import imem_pkg::*;

   localparam int DEPTH  = 64;
   localparam int ADDR_W = 6;
   localparam int DATA_W = 32;
   localparam int EW     = ADDR_W + DATA_W;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              load_req = 1'b0;
   logic              load_ack;
   logic              wr_valid = 1'b0;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              start = 1'b0;
   logic [ADDR_W:0]   prog_len = '0;
   logic              instr_valid;
   logic              instr_ready = 1'b0;
   logic [DATA_W-1:0] instr_data;
   logic [ADDR_W-1:0] instr_addr;
   logic              busy;
   logic              done;
   logic              len_err;
   state_e            dbg_state;
`ifdef IMEM_PARITY_EN
   logic              wr_par_flip = 1'b0;
   logic              par_err;
   bit                bad_par [DEPTH];
   bit                par_exp = 1'b0;
`endif

   logic [DATA_W-1:0] model_mem [DEPTH];
   logic [EW-1:0]     exp_q [$];

   int vectors = 0;
   int miscompares = 0;
   int cycle = 0;
   int hs_count = 0;
   int done_count = 0;
   int last_hs_cycle = -10;
   logic [ADDR_W-1:0] last_hs_addr = '0;
   int ready_mode = 0;
   bit abort_flag = 1'b0;
   bit hold_pend = 1'b0;
   logic [ADDR_W-1:0] hold_addr = '0;
   logic [DATA_W-1:0] hold_data = '0;

   imem_dma_seq #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .load_req    (load_req),
      .load_ack    (load_ack),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .start       (start),
      .prog_len    (prog_len),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr_data  (instr_data),
      .instr_addr  (instr_addr),
      .busy        (busy),
      .done        (done),
      .len_err     (len_err),
`ifdef IMEM_PARITY_EN
      .wr_par_flip (wr_par_flip),
      .par_err     (par_err),
`endif
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cycle++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // ---------------- consumer ready driver ----------------
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: instr_ready = 1'b1;
            1: instr_ready = ~instr_ready;
            2: instr_ready = 1'($urandom_range(0, 1));
            default: ;
         endcase
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (!rst) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend && !abort_flag) begin
            check("hold_valid", instr_valid, 1);
            check("hold_addr", instr_addr, hold_addr);
            check("hold_data", instr_data, hold_data);
         end
         if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_word: got addr %0d data 0x%0h, expected none", instr_addr, instr_data);
            end else begin
               e = exp_q.pop_front();
               check("issue_addr", instr_addr, e[EW-1:DATA_W]);
               check("issue_data", instr_data, e[DATA_W-1:0]);
            end
            hs_count++;
            last_hs_cycle = cycle;
            last_hs_addr  = instr_addr;
         end
`ifdef IMEM_PARITY_EN
         if (instr_valid) begin
            if (bad_par[instr_addr]) par_exp = 1'b1;
            check("par_err", par_err, par_exp);
         end
`endif
         if (done) begin
            done_count++;
            check("done_timing", cycle, last_hs_cycle + 1);
         end
         hold_pend = instr_valid && !instr_ready;
         hold_addr = instr_addr;
         hold_data = instr_data;
      end
   end

   // ---------------- driver tasks (entered and left at posedge+1) ----------------
   task automatic reset_dut();
      rst = 1'b0; load_req = 1'b0; start = 1'b0; wr_valid = 1'b0;
`ifdef IMEM_PARITY_EN
      par_exp = 1'b0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_load_ack", load_ack, 0);
      check("rst_wr_ready", wr_ready, 0);
      check("rst_valid", instr_valid, 0);
      check("rst_data", instr_data, 0);
      check("rst_addr", instr_addr, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_len_err", len_err, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic enter_load();
      int n;
      load_req = 1'b1;
      n = 0;
      while (!load_ack && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("load_ack_rise", load_ack, 1);
      check("wr_ready_rise", wr_ready, 1);
   endtask

   task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit flip);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      model_mem[a] = d;
`ifdef IMEM_PARITY_EN
      wr_par_flip = flip;
      bad_par[a]  = flip;
`else
      if (flip) $display("note: parity flip requested without parity build");
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic leave_load();
      wr_valid = 1'b0;
      load_req = 1'b0;
`ifdef IMEM_PARITY_EN
      wr_par_flip = 1'b0;
`endif
      @(posedge clk);
      #1;
      check("load_ack_fall", load_ack, 0);
   endtask

   task automatic run_prog(input int len, input int mode);
      int d0;
      int n;
      ready_mode = mode;
      d0 = done_count;
      for (int i = 0; i < len; i++) exp_q.push_back({ADDR_W'(i), model_mem[i]});
`ifdef IMEM_PARITY_EN
      par_exp = 1'b0;
`endif
      start = 1'b1;
      prog_len = (ADDR_W+1)'(len);
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_after_start", busy, 1);
      check("valid_after_start", instr_valid, 0);
      @(posedge clk);
      #1;
      check("first_valid", instr_valid, 1);
      check("first_addr", instr_addr, 0);
      n = 0;
      while (done_count == d0 && n < 8 * len + 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("done_seen", done_count - d0, 1);
      repeat (3) @(posedge clk);
      #1;
      check("done_once", done_count - d0, 1);
      check("queue_drained", exp_q.size(), 0);
      check("busy_after_done", busy, 0);
      exp_q.delete();
   endtask

   task automatic bad_start(input int len);
      start = 1'b1;
      prog_len = (ADDR_W+1)'(len);
      @(posedge clk);
      #1;
      start = 1'b0;
      check("len_err_set", len_err, 1);
      check("busy_bad_len", busy, 0);
      repeat (2) @(posedge clk);
      #1;
      check("valid_bad_len", instr_valid, 0);
   endtask

   task automatic abort_test();
      int base;
      int d0;
      int n;
      base = hs_count;
      d0 = done_count;
      ready_mode = 4;
      instr_ready = 1'b1;
      for (int i = 0; i < 10; i++) exp_q.push_back({ADDR_W'(i), model_mem[i]});
      start = 1'b1;
      prog_len = (ADDR_W+1)'(10);
      @(posedge clk);
      #1;
      start = 1'b0;
      n = 0;
      while (hs_count < base + 3 && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      @(posedge clk);
      #1;
      abort_flag = 1'b1;
      instr_ready = 1'b0;
      load_req = 1'b1;
      @(posedge clk);
      #1;
      check("abort_valid", instr_valid, 0);
      check("abort_ack", load_ack, 1);
      check("abort_busy", busy, 0);
      check("abort_handshakes", hs_count - base, 3);
      check("abort_len_err", len_err, 0);
      exp_q.delete();
      write_word(6'd40, 32'hA5A5_0040, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_done", done_count - d0, 0);
      leave_load();
      abort_flag = 1'b0;
      ready_mode = 0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [DATA_W-1:0] plan [16];
      plan[0] = 32'hFFFF_FFFF;
      plan[1] = 32'h0000_0001;
      plan[2] = 32'h0000_0002;
      plan[3] = 32'h0000_0000;
      for (int i = 4; i < 16; i++) plan[i] = 32'h1 << (i + 8);

      @(posedge clk);
      #1;
      reset_dut();

      enter_load();
      for (int i = 0; i < DEPTH; i++) write_word(ADDR_W'(i), $urandom, 1'b0);
      for (int i = 0; i < 16; i++) write_word(ADDR_W'(i + 1), plan[i], 1'b0);
      leave_load();

      run_prog(17, 0);
      check("last_addr_17", last_hs_addr, 16);

      run_prog(4, 1);

      bad_start(0);
      bad_start(DEPTH + 1);
      check("len_err_sticky", len_err, 1);
      run_prog(2, 0);
      check("len_err_cleared", len_err, 0);

      abort_test();

      run_prog(DEPTH, 2);
      check("last_addr_full", last_hs_addr, DEPTH - 1);

      // start and load_req together: load wins
      start = 1'b1;
      load_req = 1'b1;
      prog_len = (ADDR_W+1)'(4);
      @(posedge clk);
      #1;
      start = 1'b0;
      check("prio_ack", load_ack, 1);
      check("prio_busy", busy, 0);
      repeat (2) @(posedge clk);
      #1;
      check("prio_no_valid", instr_valid, 0);
      leave_load();

      // reset mid-run, memory must survive
      ready_mode = 2;
      for (int i = 0; i < 20; i++) exp_q.push_back({ADDR_W'(i), model_mem[i]});
      start = 1'b1;
      prog_len = (ADDR_W+1)'(20);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      abort_flag = 1'b1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_valid", instr_valid, 0);
      check("midrst_busy", busy, 0);
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      abort_flag = 1'b0;
      run_prog(16, 0);

      for (int r = 0; r < 6; r++) begin
         int k;
         enter_load();
         k = $urandom_range(1, 8);
         for (int j = 0; j < k; j++) write_word(ADDR_W'($urandom_range(0, DEPTH - 1)), $urandom, 1'b0);
         leave_load();
         run_prog($urandom_range(1, DEPTH), $urandom_range(0, 2));
      end

`ifdef IMEM_PARITY_EN
      enter_load();
      write_word(6'd5, 32'h1234_5678, 1'b1);
      leave_load();
      run_prog(8, 0);
      check("par_err_sticky", par_err, 1);
      run_prog(2, 0);
      check("par_err_cleared", par_err, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
